mips_prog_loader: RTL and testbench

- Host-side writer that fills the 1024×32 unified instruction/data memory before the MIPS_32 pipeline runs.
- Accepts a framed word stream over a valid/ready handshake: base address, word count, payload, then XOR checksum.
- Issues one registered memory write per accepted payload word.
- Holds the core stopped until a frame is loaded and verified, then releases it via core_run.

---
 rtl/mips_prog_loader_if.sv | 29 ++
 rtl/mips_prog_loader.sv | 147 ++++++++++++++
 tb/tb_mips_prog_loader.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_prog_loader_if.sv
// Host stream and memory-write bundle for the MIPS program loader.
// The master side drives the framed word stream; the slave side is the loader.
interface mips_prog_loader_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);
  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic              core_run;
  logic [ADDR_W:0]   words_written;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, core_run, words_written
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, core_run, words_written
  );
endinterface

// File: rtl/mips_prog_loader.sv
// Loads a framed word stream (base, count, payload, XOR checksum) into the unified memory
// and releases the core only after a frame has been written and its checksum verified.
module mips_prog_loader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input logic               clk1,
  input logic               rst,
  mips_prog_loader_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle, StHdrAddr, StHdrLen, StLoad, StChk, StDone, StErr
  } state_e;

  localparam logic [ADDR_W:0] MemWords = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [DATA_W-1:0] csum_q, csum_d;
  logic [ADDR_W:0]   ww_q, ww_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic            in_ready, busy, done, err, core_run;
  logic            xfer;
  logic [ADDR_W:0] room;
  logic            len_too_big;
  logic [ADDR_W:0] ww_inc;

  assign xfer   = bus.in_valid & in_ready;
  assign room   = MemWords - {1'b0, base_q};
  assign ww_inc = ww_q + 1'b1;
  // Any count bit above the address range already exceeds the memory, so wrap is impossible.
  assign len_too_big = (|bus.in_data[DATA_W-1:ADDR_W+1]) || (bus.in_data[ADDR_W:0] > room);

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q     <= StIdle;
      base_q      <= '0;
      len_q       <= '0;
      csum_q      <= '0;
      ww_q        <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      csum_q      <= csum_d;
      ww_q        <= ww_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    csum_d      = csum_q;
    ww_d        = ww_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (bus.start) begin
          state_d = StHdrAddr;
          ww_d    = '0;
          csum_d  = '0;
        end
      end
      StHdrAddr: begin
        if (xfer) begin
          base_d  = bus.in_data[ADDR_W-1:0];
          state_d = (|bus.in_data[DATA_W-1:ADDR_W]) ? StErr : StHdrLen;
        end
      end
      StHdrLen: begin
        if (xfer) begin
          len_d = bus.in_data[ADDR_W:0];
          if (len_too_big) begin
            state_d = StErr;
          end else if (bus.in_data == '0) begin
            state_d = StChk;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        if (xfer) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = base_q + ww_q[ADDR_W-1:0];
          mem_wdata_d = bus.in_data;
          csum_d      = csum_q ^ bus.in_data;
          ww_d        = ww_inc;
          if (ww_inc == len_q) begin
            state_d = StChk;
          end
        end
      end
      StChk: begin
        if (xfer) begin
          state_d = (bus.in_data == csum_q) ? StDone : StErr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    core_run = 1'b0;
    unique case (state_q)
      StHdrAddr, StHdrLen, StLoad, StChk: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      StDone: begin
        done     = 1'b1;
        core_run = 1'b1;
      end
      StErr:   err = 1'b1;
      default: ;
    endcase
  end

  assign bus.in_ready      = in_ready;
  assign bus.busy          = busy;
  assign bus.done          = done;
  assign bus.err           = err;
  assign bus.core_run      = core_run;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.words_written = ww_q;

endmodule

// File: tb/tb_mips_prog_loader.sv
// Frame-level bench: expected writes and frame outcomes are derived from frame contents and
// checked against every memory strobe and the end-of-frame status.
module tb_mips_prog_loader;

  logic clk;
  logic rst;
  bit   chk_en;
  bit   cur_kind;
  bit   prev_pay;
  int   total;
  int   bad;

  logic [9:0]  exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] pl_q[$];

  mips_prog_loader_if bus ();

  mips_prog_loader dut (
    .clk1 (clk),
    .rst  (rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Sampled between edges: outputs reflect the last posedge, inputs are what the next one sees.
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      check("we_timing", bus.mem_we, prev_pay);
      if (bus.mem_we) begin
        if (exp_addr.size() == 0) begin
          check("unexpected_write", 1'b1, 1'b0);
        end else begin
          check("waddr", bus.mem_addr, exp_addr.pop_front());
          check("wdata", bus.mem_wdata, exp_data.pop_front());
        end
      end
      check("run_while_busy", bus.core_run & bus.busy, 1'b0);
      check("ready_vs_busy", bus.in_ready, bus.busy);
      check("run_vs_done", bus.core_run, bus.done);
      check("done_and_err", bus.done & bus.err, 1'b0);
    end
    prev_pay = bus.in_valid & bus.in_ready & cur_kind & ~rst;
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, bus.in_ready, 0);
    check({tag, "_we"}, bus.mem_we, 0);
    check({tag, "_addr"}, bus.mem_addr, 0);
    check({tag, "_wdata"}, bus.mem_wdata, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_err"}, bus.err, 0);
    check({tag, "_run"}, bus.core_run, 0);
    check({tag, "_ww"}, bus.words_written, 0);
  endtask

  // gaps: 0 = valid held high, 1 = one idle cycle before every word, 2 = random idle cycles
  task automatic send_word(input logic [31:0] w, input bit kind, input int gaps);
    int t;
    if (gaps == 1 || (gaps == 2 && $urandom_range(0, 1) == 1)) begin
      bus.in_valid = 1'b0;
      cur_kind     = 1'b0;
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    cur_kind     = kind;
    t = 0;
    while (!bus.in_ready && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL handshake_timeout: in_ready=0 want 1");
      $fatal(1, "loader stopped accepting words");
    end
    @(negedge clk);
  endtask

  task automatic end_check(input string tag, input bit d, input bit e, input logic [10:0] ww);
    bus.in_valid = 1'b0;
    cur_kind     = 1'b0;
    @(negedge clk);
    check({tag, "_done"}, bus.done, d);
    check({tag, "_err"}, bus.err, e);
    check({tag, "_run"}, bus.core_run, d);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_ww"}, bus.words_written, ww);
    check({tag, "_pending_writes"}, exp_addr.size(), 0);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Payload comes from pl_q; outcome is predicted purely from the frame's words.
  task automatic run_frame(input logic [31:0] base_w, input logic [31:0] n,
                           input logic [31:0] chk_w, input int gaps, input bit mid_start);
    bit          hdr_bad;
    bit          len_bad;
    bit          good;
    logic [31:0] x;
    logic [9:0]  b;
    hdr_bad = (base_w >> 10) != 0;
    b       = base_w[9:0];
    len_bad = !hdr_bad && (64'(n) > 64'd1024 - 64'(b));
    pulse_start();
    check("start_busy", bus.busy, 1);
    check("start_clear", {bus.done, bus.err, bus.core_run, bus.words_written}, 0);
    send_word(base_w, 1'b0, gaps);
    if (hdr_bad) begin
      end_check("hdr_reject", 1'b0, 1'b1, 11'd0);
      return;
    end
    send_word(n, 1'b0, gaps);
    if (len_bad) begin
      end_check("len_reject", 1'b0, 1'b1, 11'd0);
      return;
    end
    x = '0;
    for (int i = 0; i < int'(n); i++) begin
      x ^= pl_q[i];
      exp_addr.push_back(b + 10'(i));
      exp_data.push_back(pl_q[i]);
      send_word(pl_q[i], 1'b1, gaps);
      if (mid_start && i == 0) begin
        bus.in_valid = 1'b0;
        cur_kind     = 1'b0;
        pulse_start();
      end
    end
    send_word(chk_w, 1'b0, gaps);
    good = (chk_w == x);
    end_check("frame", good, !good, n[10:0]);
  endtask

  initial begin
    logic [31:0] base_w;
    logic [31:0] n;
    logic [31:0] x;
    logic [31:0] d;
    int          r;
    total        = 0;
    bad          = 0;
    chk_en       = 1'b0;
    cur_kind     = 1'b0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst    = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    pl_q = '{32'h11, 32'h22, 32'h44};
    run_frame(32'h0, 32'd3, 32'h77, 0, 1'b0);
    check("f1_done_lit", bus.done, 1);
    check("f1_ww_lit", bus.words_written, 3);

    run_frame(32'h0, 32'd3, 32'h76, 0, 1'b0);
    check("f2_err_lit", bus.err, 1);
    check("f2_run_lit", bus.core_run, 0);
    check("f2_ww_lit", bus.words_written, 3);

    run_frame(32'h3FE, 32'd3, 32'h0, 0, 1'b0);
    check("f3_err_lit", bus.err, 1);

    pl_q = '{32'hDEAD_BEEF, 32'h1234_5678};
    run_frame(32'h3FE, 32'd2, 32'hDEAD_BEEF ^ 32'h1234_5678, 0, 1'b0);
    check("f4_done_lit", bus.done, 1);

    run_frame(32'h400, 32'd1, 32'h0, 0, 1'b0);
    check("f5_err_lit", bus.err, 1);

    run_frame(32'h5, 32'd0, 32'h0, 0, 1'b0);
    check("f6_done_lit", bus.done, 1);
    check("f6_ww_lit", bus.words_written, 0);

    pl_q = '{32'hA, 32'hB, 32'hC, 32'hD};
    run_frame(32'h10, 32'd4, 32'hA ^ 32'hB ^ 32'hC ^ 32'hD, 1, 1'b1);
    check("f7_done_lit", bus.done, 1);

    // Reset after two of five payload words abandons the frame.
    pulse_start();
    send_word(32'h100, 1'b0, 0);
    send_word(32'd5, 1'b0, 0);
    for (int i = 0; i < 2; i++) begin
      d = $urandom;
      exp_addr.push_back(10'h100 + 10'(i));
      exp_data.push_back(d);
      send_word(d, 1'b1, 0);
    end
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    cur_kind     = 1'b0;
    @(negedge clk);
    check_all_zero("rst_mid");
    rst = 1'b0;
    check("rst_mid_pending", exp_addr.size(), 0);
    pl_q = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h10};
    run_frame(32'h100, 32'd5, 32'h1F, 0, 1'b0);
    check("after_rst_done_lit", bus.done, 1);

    for (int f = 0; f < 40; f++) begin
      r      = int'($urandom_range(0, 9));
      base_w = (r < 3) ? 32'(1024 - $urandom_range(1, 6)) : 32'($urandom_range(0, 1023));
      if (r == 9) base_w = base_w | (32'h1 << $urandom_range(10, 31));
      n = 32'($urandom_range(0, 7));
      if (r == 8) n = n | 32'h8000_0000;
      pl_q.delete();
      x = '0;
      for (int i = 0; i < 8; i++) begin
        d = $urandom;
        pl_q.push_back(d);
        if (i < int'(n[2:0])) x ^= d;
      end
      if ($urandom_range(0, 3) == 0) x = x ^ (32'h1 << $urandom_range(0, 31));
      run_frame(base_w, n, x, 2, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
